weight_feed_sa: RTL and testbench
=================================

Name: weight_feed_sa

Overview:
Parametrised weight/activation feeder for the systolic MAC array. It accepts one tile per handshake: LANES lane-words of DEPTH elements, DW bits each. It serialises each lane one element per advance cycle, and can optionally skew lanes diagonally (lane i delayed i cycles) to match the array wavefront. A shadow (ping-pong) register lets the next tile load while the current one streams, so consecutive tiles play out with no bubble.

Parameters:
LANES, 4, number of output lanes (array rows); >=1
DEPTH, 4, elements per lane per tile; >=2
DW, 8, element width in bits
SKEW, 1, 1 = lane i output delayed i advance cycles; 0 = all lanes aligned

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
load_valid  in  1  tile offered on load_data
load_ready  out  1  shadow register empty; tile accepted when load_valid && load_ready
load_data  in  LANES*DEPTH*DW  lane i word = bits [(i+1)*DEPTH*DW-1 : i*DEPTH*DW]
load_lsb_first  in  1  element order for this tile; sampled with load_data
adv  in  1  advance enable; when 0 all streaming state freezes
flush  in  1  synchronous abort of streamed and buffered data
dout  out  LANES*DW  lane i element = bits [(i+1)*DW-1 : i*DW]
dout_valid  out  LANES  per-lane element valid
busy  out  1  active tile or any skew stage holds valid data
done  out  1  one-cycle pulse: last element of a tile left the last lane

Behaviour:
- Reset, clk and rstn: rstn is asynchronous, active-low; clock is clk. Reset clears shadow, active buffer, skew chains and state. Reset values: dout=0, dout_valid=0, busy=0, done=0, load_ready=1.
- Reset mid-tile discards everything. No partial tile resumes.
- Shadow register:
  - Filled on load_valid && load_ready, independent of adv.
  - load_ready = ~shadow_full && ~flush.
  - Accepting a tile stores load_lsb_first alongside it.
- State machine IDLE / STREAM, with issue counter k in 0..DEPTH-1.
  - IDLE: on an adv edge with shadow full, active <= shadow, shadow empties, k=0, go to STREAM.
  - STREAM: each adv edge issues element k of every lane into lane stage 0 and increments k.
  - Element order: MSB-first issues element DEPTH-1-k (top DW bits first, left shift). LSB-first issues element k (right shift). Vacated bits fill with 0.
- Tile boundary: on the adv edge issuing k=DEPTH-1:
  - if shadow is full, active <= shadow on the same edge and k=0, so the next tile's element 0 issues on the following adv edge (gapless);
  - otherwise return to IDLE.
- Latency: the transfer edge is E0. Lane 0 shows element 0 after adv edge E1. Lane i shows it after E(1+i*SKEW). Latency counts adv edges only.
- Skew chains:
  - Lane i has i*SKEW registered stages carrying {data, valid, last}. They shift only on adv.
  - dout is registered and updates only on adv edges. Lane slots carrying no valid element present 0 with dout_valid=0.
- done:
  - Registered, high for exactly one cycle after the adv edge on which lane LANES-1 outputs the last element of a tile.
  - That edge is E(DEPTH+(LANES-1)*SKEW) for an isolated tile.
  - Back-to-back tiles produce one done per tile.
- busy = STREAM || any stage valid || any dout_valid.
- adv=0: all issue, chain and dout registers hold, done is 0, and the shadow can still load.
- flush=1 (synchronous): on the next edge, clear active, shadow, chains, dout, dout_valid and done, and go to IDLE. flush beats adv and load in the same cycle; no tile is accepted that cycle.

Optional Feature:
WEIGHT_FEED_SA_CNT_EN:
- Defined: adds output tile_cnt [15:0], counting tiles whose done pulsed. It wraps 0xFFFF -> 0, and is cleared by rstn and by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- LANES=4, DEPTH=4, DW=8, SKEW=0, MSB-first; lane words 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; adv=1 -> lane0 outputs 11,22,33,44 on E1..E4, all lanes aligned, dout_valid=4'hF for 4 cycles, done one cycle after E4.
- Same tile, SKEW=1 -> lane3 outputs DD,EE,FF,00 on E4..E7; dout_valid walks 0001,0011,0111,1111,1110,1100,1000; done one cycle after E7.
- LSB-first tile with lane0 word 0x11223344 -> lane0 outputs 44,33,22,11.
- Two tiles back-to-back, second loaded during streaming -> lane0 shows no zero/invalid gap between tiles; two done pulses 4 cycles apart; load_ready drops while shadow holds the second tile.
- adv toggled 1,0,1,0 mid-stream -> outputs and k hold on adv=0 cycles; element sequence unchanged; done delayed by the number of stalled cycles.
- flush asserted at E2 with load_valid=1 -> next cycle dout=0, dout_valid=0, busy=0, load_ready=1, no done, tile not accepted. Repeat using rstn low instead of flush -> same result immediately.

Source files
------------

// File: rtl/weight_feed_sa.sv
`default_nettype none
// ============================================================================
// Module   : weight_feed_sa
// Summary  : Ping-pong tile feeder serialising LANES lane-words into a
//            systolic array, with optional diagonal lane skew.
//            Define WEIGHT_FEED_SA_CNT_EN to add the tile_cnt output.
// Revision : 1.0  initial release
// ============================================================================
module weight_feed_sa #(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int SKEW  = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [LANES*DEPTH*DW-1:0] load_data,
    input  logic                      load_lsb_first,
    input  logic                      adv,
    input  logic                      flush,
    output logic [LANES*DW-1:0]       dout,
    output logic [LANES-1:0]          dout_valid,
    output logic                      busy,
`ifdef WEIGHT_FEED_SA_CNT_EN
    output logic                      done,
    output logic [15:0]               tile_cnt
`else
    output logic                      done
`endif
);

    localparam int              c_KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_KW-1:0] c_KLAST = c_KW'(DEPTH - 1);
    localparam int              c_LN    = (LANES - 1) * SKEW;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [c_KW-1:0]           r_k, w_k_nxt;
    logic                      w_xfer, w_issue, w_accept, w_iss_l;
    logic                      w_last_tail, w_done_set;
    int                        w_off;

    logic [LANES*DEPTH*DW-1:0] r_shadow, r_act;
    logic                      r_shadow_full, r_shadow_lsb, r_act_lsb;

    logic [LANES-1:0][DW-1:0]  w_iss_d, w_tail_d, r_dout;
    logic [LANES-1:0]          w_tail_v, w_chain_any, r_dout_valid;
    logic                      r_done;

    assign load_ready = ~r_shadow_full & ~flush;
    assign w_accept   = load_valid & load_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_xfer      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (adv && r_shadow_full) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = S_STREAM;
                    w_k_nxt     = '0;
                end
            end
            S_STREAM: begin
                if (adv) begin
                    w_issue = 1'b1;
                    if (r_k == c_KLAST) begin
                        // Tile boundary: chain straight into a waiting tile
                        w_k_nxt = '0;
                        if (r_shadow_full) w_xfer = 1'b1;
                        else               w_state_nxt = S_IDLE;
                    end else begin
                        w_k_nxt = r_k + c_KW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = '0;
            w_xfer      = 1'b0;
            w_issue     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_shadow_lsb  <= 1'b0;
            r_act         <= '0;
            r_act_lsb     <= 1'b0;
        end else if (flush) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_shadow_lsb  <= 1'b0;
            r_act         <= '0;
            r_act_lsb     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow      <= load_data;
                r_shadow_lsb  <= load_lsb_first;
                r_shadow_full <= 1'b1;
            end else if (w_xfer) begin
                r_shadow_full <= 1'b0;
            end
            if (w_xfer) begin
                r_act     <= r_shadow;
                r_act_lsb <= r_shadow_lsb;
            end
        end
    end

    // Bit offset of the element issued this cycle within a lane word
    always_comb begin
        w_off = DW * (r_act_lsb ? int'(r_k) : (DEPTH - 1 - int'(r_k)));
    end

    assign w_iss_l = w_issue && (r_k == c_KLAST);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int c_N = gi * SKEW;

        assign w_iss_d[gi] = w_issue ? r_act[gi*DEPTH*DW + w_off +: DW] : '0;

        if (c_N == 0) begin : g_direct
            assign w_tail_d[gi]    = w_iss_d[gi];
            assign w_tail_v[gi]    = w_issue;
            assign w_chain_any[gi] = 1'b0;
        end else begin : g_chain
            logic [c_N-1:0][DW-1:0] r_cd;
            logic [c_N-1:0]         r_cv;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_cd <= '0;
                    r_cv <= '0;
                end else if (flush) begin
                    r_cd <= '0;
                    r_cv <= '0;
                end else if (adv) begin
                    r_cd[0] <= w_iss_d[gi];
                    r_cv[0] <= w_issue;
                    for (int s = 1; s < c_N; s++) begin
                        r_cd[s] <= r_cd[s-1];
                        r_cv[s] <= r_cv[s-1];
                    end
                end
            end

            assign w_tail_d[gi]    = r_cd[c_N-1];
            assign w_tail_v[gi]    = r_cv[c_N-1];
            assign w_chain_any[gi] = |r_cv;
        end
    end

    // Only the final lane's end-of-tile marker drives done
    if (c_LN == 0) begin : g_last_direct
        assign w_last_tail = w_iss_l;
    end else begin : g_last_chain
        logic [c_LN-1:0] r_lp;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_lp <= '0;
            end else if (flush) begin
                r_lp <= '0;
            end else if (adv) begin
                r_lp[0] <= w_iss_l;
                for (int s = 1; s < c_LN; s++) begin
                    r_lp[s] <= r_lp[s-1];
                end
            end
        end

        assign w_last_tail = r_lp[c_LN-1];
    end

    assign w_done_set = adv && w_tail_v[LANES-1] && w_last_tail;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout       <= '0;
            r_dout_valid <= '0;
            r_done       <= 1'b0;
        end else if (flush) begin
            r_dout       <= '0;
            r_dout_valid <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (adv) begin
                r_dout       <= w_tail_d;
                r_dout_valid <= w_tail_v;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign done       = r_done;
    assign busy       = (r_state == S_STREAM) || (|w_chain_any) || (|r_dout_valid);

`ifdef WEIGHT_FEED_SA_CNT_EN
    logic [15:0] r_tile_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tile_cnt <= '0;
        end else if (flush) begin
            r_tile_cnt <= '0;
        end else if (w_done_set) begin
            r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

    assign tile_cnt = r_tile_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_feed_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_feed_sa
// Summary  : Directed bench for weight_feed_sa; instance u_s0 uses SKEW=0,
//            instance u_s1 uses SKEW=1, both driven by the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_weight_feed_sa;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         load_valid = 1'b0;
    logic [127:0] load_data = '0;
    logic         load_lsb_first = 1'b0;
    logic         adv = 1'b0;
    logic         flush = 1'b0;

    logic         lr0, lr1, busy0, busy1, done0, done1;
    logic [31:0]  dout0, dout1;
    logic [3:0]   dv0, dv1;
`ifdef WEIGHT_FEED_SA_CNT_EN
    logic [15:0]  cnt0, cnt1;
`endif

    int checks = 0;
    int passed = 0;

    logic [127:0] tile_a = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
    logic [127:0] tile_b = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hA1B2C3D4};
    logic [7:0]   msb [0:3][0:3] = '{'{8'h11, 8'h22, 8'h33, 8'h44},
                                     '{8'h55, 8'h66, 8'h77, 8'h88},
                                     '{8'h99, 8'hAA, 8'hBB, 8'hCC},
                                     '{8'hDD, 8'hEE, 8'hFF, 8'h00}};
    logic [3:0]   vwalk [0:8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [7:0]   lsb0 [0:3]  = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0]   b2b0 [0:7]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic         stall_adv [1:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]   stall_d   [1:7] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h44, 8'h00};
    logic         stall_v   [1:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         stall_dn  [1:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    weight_feed_sa #(.LANES(4), .DEPTH(4), .DW(8), .SKEW(0)) u_s0 (
        .clk(clk), .rstn(rstn), .load_valid(load_valid), .load_ready(lr0),
        .load_data(load_data), .load_lsb_first(load_lsb_first), .adv(adv),
        .flush(flush), .dout(dout0), .dout_valid(dv0), .busy(busy0),
`ifdef WEIGHT_FEED_SA_CNT_EN
        .done(done0), .tile_cnt(cnt0)
`else
        .done(done0)
`endif
    );

    weight_feed_sa #(.LANES(4), .DEPTH(4), .DW(8), .SKEW(1)) u_s1 (
        .clk(clk), .rstn(rstn), .load_valid(load_valid), .load_ready(lr1),
        .load_data(load_data), .load_lsb_first(load_lsb_first), .adv(adv),
        .flush(flush), .dout(dout1), .dout_valid(dv1), .busy(busy1),
`ifdef WEIGHT_FEED_SA_CNT_EN
        .done(done1), .tile_cnt(cnt1)
`else
        .done(done1)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; load_valid = 1'b0; adv = 1'b0; flush = 1'b0; load_lsb_first = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic load_tile(input logic [127:0] d, input logic lsb);
        load_valid = 1'b1; load_data = d; load_lsb_first = lsb; adv = 1'b0;
        tick();
        load_valid = 1'b0;
    endtask

    // Expected SKEW=1 output word after adv edge En: lane i carries element n-1-i
    function automatic logic [31:0] exp_skew(input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int j = n - 1 - i;
            if (j >= 0 && j < 4) r[i*8 +: 8] = msb[i][j];
        end
        return r;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        checks++; if ({dout0, dv0, busy0, done0, lr0} !== {32'h0, 4'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_s0 got %h exp %h", {dout0, dv0, busy0, done0, lr0}, {32'h0, 4'h0, 3'b001});
        else passed++;
        checks++; if ({dout1, dv1, busy1, done1, lr1} !== {32'h0, 4'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_s1 got %h exp %h", {dout1, dv1, busy1, done1, lr1}, {32'h0, 4'h0, 3'b001});
        else passed++;
    endtask

    task automatic test_msb_tile();
        logic [31:0] e0;
        do_reset();
        load_tile(tile_a, 1'b0);
        adv = 1'b1;
        tick();
        checks++; if ({busy0, busy1, dv0, dv1} !== {2'b11, 8'h00})
            $display("FAIL msb_e0 got %b exp %b", {busy0, busy1, dv0, dv1}, {2'b11, 8'h00});
        else passed++;
        for (int n = 1; n <= 8; n++) begin
            tick();
            e0 = (n <= 4) ? {msb[3][n-1], msb[2][n-1], msb[1][n-1], msb[0][n-1]} : 32'h0;
            checks++; if (dout0 !== e0)
                $display("FAIL msb_dout_s0 n=%0d got %h exp %h", n, dout0, e0);
            else passed++;
            checks++; if (dv0 !== ((n <= 4) ? 4'hF : 4'h0))
                $display("FAIL msb_valid_s0 n=%0d got %h exp %h", n, dv0, (n <= 4) ? 4'hF : 4'h0);
            else passed++;
            checks++; if (done0 !== (n == 4))
                $display("FAIL msb_done_s0 n=%0d got %b exp %b", n, done0, n == 4);
            else passed++;
            checks++; if (dout1 !== exp_skew(n))
                $display("FAIL skew_dout_s1 n=%0d got %h exp %h", n, dout1, exp_skew(n));
            else passed++;
            checks++; if (dv1 !== vwalk[n])
                $display("FAIL skew_valid_s1 n=%0d got %b exp %b", n, dv1, vwalk[n]);
            else passed++;
            checks++; if (done1 !== (n == 7))
                $display("FAIL skew_done_s1 n=%0d got %b exp %b", n, done1, n == 7);
            else passed++;
        end
        checks++; if ({busy0, busy1} !== 2'b00)
            $display("FAIL msb_idle_busy got %b exp 00", {busy0, busy1});
        else passed++;
    endtask

    task automatic test_lsb_tile();
        do_reset();
        load_tile(tile_a, 1'b1);
        adv = 1'b1;
        tick();
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++; if (dout0[7:0] !== lsb0[n-1] || dout1[7:0] !== lsb0[n-1])
                $display("FAIL lsb_lane0 n=%0d got %h/%h exp %h", n, dout0[7:0], dout1[7:0], lsb0[n-1]);
            else passed++;
        end
        checks++; if (dout0[31:24] !== 8'hDD)
            $display("FAIL lsb_lane3_last got %h exp dd", dout0[31:24]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed;
        do_reset();
        load_tile(tile_a, 1'b0);
        adv = 1'b1;
        tick();
        for (int n = 1; n <= 12; n++) begin
            load_valid = (n == 1);
            load_data  = tile_b;
            tick();
            load_valid = 1'b0;
            ed = (n <= 8) ? b2b0[n-1] : 8'h00;
            checks++; if (dout0[7:0] !== ed || dv0[0] !== (n <= 8))
                $display("FAIL b2b_lane0 n=%0d got %h/%b exp %h/%b", n, dout0[7:0], dv0[0], ed, n <= 8);
            else passed++;
            checks++; if (done0 !== (n == 4 || n == 8) || done1 !== (n == 7 || n == 11))
                $display("FAIL b2b_done n=%0d got %b%b exp %b%b", n, done0, done1, n == 4 || n == 8, n == 7 || n == 11);
            else passed++;
            checks++; if (lr0 !== !(n >= 1 && n <= 3))
                $display("FAIL b2b_ready n=%0d got %b exp %b", n, lr0, !(n >= 1 && n <= 3));
            else passed++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        load_tile(tile_a, 1'b0);
        adv = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            adv = stall_adv[c];
            tick();
            checks++; if (dout0[7:0] !== stall_d[c] || dv0[0] !== stall_v[c] || done0 !== stall_dn[c])
                $display("FAIL stall c=%0d got %h/%b/%b exp %h/%b/%b", c, dout0[7:0], dv0[0], done0,
                         stall_d[c], stall_v[c], stall_dn[c]);
            else passed++;
            checks++; if (dout1[7:0] !== stall_d[c])
                $display("FAIL stall_s1 c=%0d got %h exp %h", c, dout1[7:0], stall_d[c]);
            else passed++;
        end
    endtask

    task automatic test_abort(input logic use_reset);
        do_reset();
        load_tile(tile_a, 1'b0);
        adv = 1'b1;
        tick();
        tick();
        tick();
        load_valid = 1'b1;
        load_data  = tile_b;
        if (use_reset) begin
            rstn = 1'b0;
            #1;
        end else begin
            flush = 1'b1;
            #1;
            checks++; if (lr0 !== 1'b0)
                $display("FAIL flush_ready_low got %b exp 0", lr0);
            else passed++;
            tick();
            flush = 1'b0;
            load_valid = 1'b0;
            #1;
        end
        checks++; if ({dout0, dv0, busy0, done0, lr0} !== {32'h0, 4'h0, 3'b001})
            $display("FAIL abort_s0 rst=%b got %h exp %h", use_reset, {dout0, dv0, busy0, done0, lr0}, {32'h0, 4'h0, 3'b001});
        else passed++;
        checks++; if ({dout1, dv1, busy1, done1, lr1} !== {32'h0, 4'h0, 3'b001})
            $display("FAIL abort_s1 rst=%b got %h exp %h", use_reset, {dout1, dv1, busy1, done1, lr1}, {32'h0, 4'h0, 3'b001});
        else passed++;
        if (use_reset) begin
            load_valid = 1'b0;
            tick();
            rstn = 1'b1;
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if ({dv0, dv1, busy0, busy1, done0, done1} !== 12'h0)
                $display("FAIL abort_idle rst=%b n=%0d got %h exp 000", use_reset, n, {dv0, dv1, busy0, busy1, done0, done1});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_msb_tile();
        test_lsb_tile();
        test_back_to_back();
        test_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
